// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the boot-time instruction-memory loader.
package imem_loader_pkg;

   localparam int unsigned LEN_BYTES  = 4;
   localparam int unsigned WORD_BYTES = 4;
   localparam int unsigned CSUM_W     = 32;
   localparam int unsigned ADDR_W     = 32;
   localparam int unsigned DATA_W     = 32;
   localparam int unsigned BYTE_W     = 8;

   typedef logic [2:0] state_t;

   localparam logic [2:0] S_LEN  = 3'd0;
   localparam logic [2:0] S_DATA = 3'd1;
   localparam logic [2:0] S_CSUM = 3'd2;
   localparam logic [2:0] S_DONE = 3'd3;
   localparam logic [2:0] S_ERR  = 3'd4;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Little-endian byte-to-word assembler; word_valid_c/word_c are combinational on the
// accepting cycle so the parent can register the write on the same edge.
module loader_word_packer
   import imem_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              byte_valid,
   input  logic [BYTE_W-1:0] byte_data,
   output logic              word_valid_c,
   output logic [DATA_W-1:0] word_c
);

   localparam int unsigned CNT_W = $clog2(WORD_BYTES);
   localparam int unsigned SHR_W = DATA_W - BYTE_W;

   logic [CNT_W-1:0] cnt_q;
   logic [SHR_W-1:0] shift_q;

   // Newest byte enters at the top, so after three bytes the first sits in [7:0].
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         shift_q <= '0;
      end else if (clear) begin
         cnt_q   <= '0;
         shift_q <= '0;
      end else if (byte_valid) begin
         cnt_q   <= cnt_q + CNT_W'(1);
         shift_q <= {byte_data, shift_q[SHR_W-1:BYTE_W]};
      end
   end

   always_comb begin
      word_valid_c = byte_valid && (cnt_q == CNT_W'(WORD_BYTES - 1));
      word_c       = {byte_data, shift_q};
   end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams a length-prefixed image into instruction memory and holds the
// core in reset until it lands. Define IMEM_LOADER_CHECKSUM_EN to verify a trailing sum.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned IMEM_DEPTH = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rx_valid,
   input  logic [BYTE_W-1:0] rx_data,
   output logic              rx_ready,
   input  logic              load_req,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [DATA_W-1:0] imem_wdata,
   output logic              core_rst_n,
   output logic              done,
   output logic              error
);

   localparam int unsigned IDX_W = $clog2(IMEM_DEPTH + 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam logic [2:0] S_AFTER = S_CSUM;
`else
   localparam logic [2:0] S_AFTER = S_DONE;
`endif

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  n_q, n_d, idx_q, idx_d, idx_inc;
   logic              we_d, done_d, error_d, core_rst_n_d;
   logic [ADDR_W-1:0] addr_d;
   logic [DATA_W-1:0] wdata_d;
   logic              accept, clear, word_valid;
   logic [DATA_W-1:0] word;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [CSUM_W-1:0] sum_q, sum_d;
`endif

   // Readiness depends on state alone so the upstream handshake never loops back.
   always_comb begin
      rx_ready = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
      accept   = rx_valid && rx_ready;
      idx_inc  = idx_q + IDX_W'(1);
   end

   loader_word_packer u_packer (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear        (clear),
      .byte_valid   (accept),
      .byte_data    (rx_data),
      .word_valid_c (word_valid),
      .word_c       (word)
   );

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      idx_d   = idx_q;
      we_d    = 1'b0;
      addr_d  = imem_addr;
      wdata_d = imem_wdata;
      clear   = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_d   = sum_q;
`endif
      case (state_q)
         S_LEN: begin
            if (word_valid) begin
               if (word == '0) begin
                  state_d = S_AFTER;
               end else if (word > DATA_W'(IMEM_DEPTH)) begin
                  state_d = S_ERR;
               end else begin
                  n_d     = IDX_W'(word);
                  idx_d   = '0;
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (word_valid) begin
               we_d    = 1'b1;
               addr_d  = ADDR_W'({idx_q, 2'b00});
               wdata_d = word;
               idx_d   = idx_inc;
`ifdef IMEM_LOADER_CHECKSUM_EN
               sum_d   = sum_q + CSUM_W'(word);
`endif
               if (idx_inc == n_q) state_d = S_AFTER;
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CSUM: begin
            if (word_valid) state_d = (CSUM_W'(word) == sum_q) ? S_DONE : S_ERR;
         end
`endif
         S_DONE, S_ERR: begin
            if (load_req) begin
               state_d = S_LEN;
               clear   = 1'b1;
               n_d     = '0;
               idx_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
               sum_d   = '0;
`endif
            end
         end
         default: state_d = S_LEN;
      endcase
      done_d       = (state_d == S_DONE);
      error_d      = (state_d == S_ERR);
      core_rst_n_d = (state_d == S_DONE);
   end

   // Status flags are registered from the next state so they track state_q exactly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_LEN;
         n_q        <= '0;
         idx_q      <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         done       <= 1'b0;
         error      <= 1'b0;
         core_rst_n <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         idx_q      <= idx_d;
         imem_we    <= we_d;
         imem_addr  <= addr_d;
         imem_wdata <= wdata_d;
         done       <= done_d;
         error      <= error_d;
         core_rst_n <= core_rst_n_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_q      <= sum_d;
`endif
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and randomized images against a
// behavioural model of the expected writes and final status.
module tb_imem_loader;

   localparam int unsigned DEPTH = 1024;
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam bit CSUM = 1'b1;
`else
   localparam bit CSUM = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        load_req;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        core_rst_n;
   logic        done;
   logic        error;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] wq[$];
   logic [31:0] obs_addr[$];
   logic [31:0] obs_data[$];
   bit          obs_done[$];
   bit          obs_rst[$];

   imem_loader #(.IMEM_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .rx_ready   (rx_ready),
      .load_req   (load_req),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .core_rst_n (core_rst_n),
      .done       (done),
      .error      (error)
   );

   always #5 clk = ~clk;

   // Capture every write strobe mid-cycle together with the status seen alongside it.
   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         obs_addr.push_back(imem_addr);
         obs_data.push_back(imem_wdata);
         obs_done.push_back(done === 1'b1);
         obs_rst.push_back(core_rst_n === 1'b1);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_we"},    32'(imem_we),    32'd0);
      check({tag, "_addr"},  imem_addr,       32'd0);
      check({tag, "_wdata"}, imem_wdata,      32'd0);
      check({tag, "_crst"},  32'(core_rst_n), 32'd0);
      check({tag, "_done"},  32'(done),       32'd0);
      check({tag, "_err"},   32'(error),      32'd0);
      check({tag, "_rdy"},   32'(rx_ready),   32'd1);
   endtask

   task automatic send_byte(input logic [7:0] b, input int idle);
      int waits;
      repeat (idle) begin
         @(negedge clk);
         rx_valid = 1'b0;
         rx_data  = 8'($urandom);
      end
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
      waits    = 0;
      while (rx_ready !== 1'b1 && waits < 20) begin
         @(negedge clk);
         waits++;
      end
      if (waits >= 20) check("rx_ready_wait", 32'(rx_ready), 32'd1);
   endtask

   // gap_mode: 0 back-to-back, 1 one idle cycle before each byte, 2 random idles.
   task automatic send_word(input logic [31:0] w, input int gap_mode);
      for (int i = 0; i < 4; i++) begin
         int idle;
         idle = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
         send_byte(w[8*i +: 8], idle);
      end
   endtask

   task automatic stop_stream();
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   // Streams length n, the words in wq, and (if enabled) a trailer; then compares
   // the captured writes and final status against the expected image outcome.
   task automatic run_load(input string name, input logic [31:0] n, input int gap_mode,
                           input bit bad_csum);
      logic [31:0] sum;
      bit          exp_ok;
      int          exp_wr;
      obs_addr.delete(); obs_data.delete(); obs_done.delete(); obs_rst.delete();
      sum = 32'd0;
      send_word(n, gap_mode);
      if (n <= DEPTH) begin
         foreach (wq[i]) begin
            send_word(wq[i], gap_mode);
            sum = sum + wq[i];
         end
         if (CSUM) send_word(bad_csum ? sum + 32'd1 : sum, gap_mode);
      end
      stop_stream();
      repeat (3) @(negedge clk);

      exp_ok = (n <= DEPTH) && !(CSUM && bad_csum);
      exp_wr = (n <= DEPTH) ? int'(n) : 0;
      check({name, "_wr_count"}, 32'(obs_addr.size()), 32'(exp_wr));
      for (int i = 0; i < obs_addr.size() && i < exp_wr; i++) begin
         bit last;
         last = (i == exp_wr - 1);
         check($sformatf("%s_addr%0d", name, i), obs_addr[i], 32'(i * 4));
         check($sformatf("%s_data%0d", name, i), obs_data[i], wq[i]);
         check($sformatf("%s_done_at_wr%0d", name, i), 32'(obs_done[i]), 32'(last && exp_ok));
         check($sformatf("%s_crst_at_wr%0d", name, i), 32'(obs_rst[i]), 32'(last && exp_ok));
      end
      check({name, "_done"},  32'(done),       32'(exp_ok));
      check({name, "_error"}, 32'(error),      32'(!exp_ok));
      check({name, "_crst"},  32'(core_rst_n), 32'(exp_ok));
      check({name, "_rdy"},   32'(rx_ready),   32'd0);
   endtask

   // load_req with a byte offered: it must not be consumed, core reset re-asserts.
   task automatic restart(input string name);
      @(negedge clk);
      load_req = 1'b1;
      rx_valid = 1'b1;
      rx_data  = 8'hAB;
      @(negedge clk);
      load_req = 1'b0;
      rx_valid = 1'b0;
      check({name, "_rs_rdy"},  32'(rx_ready),   32'd1);
      check({name, "_rs_crst"}, 32'(core_rst_n), 32'd0);
      check({name, "_rs_done"}, 32'(done),       32'd0);
      check({name, "_rs_err"},  32'(error),      32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      load_req = 1'b0;
      #1;
      check_reset_values("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      wq = '{32'h00500513, 32'h00A00593};
      run_load("two_words", 32'd2, 0, 1'b0);

      restart("r1");
      run_load("two_words_gaps", 32'd2, 1, 1'b0);

      restart("r2");
      wq = '{};
      run_load("over_len", 32'(DEPTH + 1), 0, 1'b0);

      restart("r3");
      wq = '{32'h00000013};
      run_load("csum_ok", 32'd1, 0, 1'b0);

      restart("r4");
      run_load("csum_bad", 32'd1, 0, 1'b1);

      restart("r5");
      wq = '{};
      run_load("zero_len", 32'd0, 0, 1'b0);

      restart("r6");
      wq = '{};
      for (int i = 0; i < DEPTH; i++) wq.push_back($urandom);
      run_load("full_depth", 32'(DEPTH), 0, 1'b0);

      for (int t = 0; t < 8; t++) begin
         int n;
         restart($sformatf("rr%0d", t));
         n = int'($urandom_range(0, 5));
         wq = '{};
         for (int i = 0; i < n; i++) wq.push_back($urandom);
         run_load($sformatf("rand%0d", t), 32'(n), 2, 1'(($urandom >> 3) & 1));
      end

      // Abort a load after six bytes with an asynchronous reset, then reload.
      restart("r7");
      send_word(32'd2, 0);
      send_byte(8'h13, 0);
      send_byte(8'h05, 0);
      @(posedge clk);
      #2;
      rst_n    = 1'b0;
      rx_valid = 1'b0;
      #1;
      check_reset_values("midload_rst");
      @(negedge clk);
      rst_n = 1'b1;
      wq = '{32'h00500513, 32'h00A00593};
      run_load("reload", 32'd2, 0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
